// File: rtl/zx_scandoubler.sv
// Composite-sync scan doubler: splits hsync/vsync out of csync, buffers each source line
// in one bank of a two-bank line store and replays the other bank twice at full clk rate.
module zx_scandoubler #(
    parameter int unsigned DW         = 1,
    parameter int unsigned LINE_LEN   = 414,
    parameter int unsigned VS_THRESH  = 80,
    parameter int unsigned H_DE_START = 64,
    parameter int unsigned H_DE_END   = 352,
    parameter int unsigned HS_START   = 384,
    parameter int unsigned V_DE_START = 16,
    parameter int unsigned V_DE_END   = 240
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_csync_in,
    input  logic [DW-1:0] i_video_in,
    input  logic          i_invert,
    input  logic          i_scanlines,
    output logic [DW-1:0] o_video_out,
    output logic          o_hs_out,
    output logic          o_vs_out,
    output logic          o_de_out,
    output logic          o_resync,
    output logic [7:0]    o_resync_cnt
);

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [8:0]  LAST_COL = 9'(LINE_LEN - 1);
    localparam logic [9:0]  LEN_W    = 10'(LINE_LEN);
    localparam logic [7:0]  VS_T     = 8'(VS_THRESH);
    localparam logic [9:0]  HS_S     = 10'(HS_START);
    localparam logic [9:0]  HDE_S    = 10'(H_DE_START);
    localparam logic [9:0]  HDE_E    = 10'(H_DE_END);
    localparam logic [10:0] VDE_S    = 11'(V_DE_START);
    localparam logic [10:0] VDE_E    = 11'(V_DE_END);

    logic          r_csd;
    logic [7:0]    r_sync_len;
    logic [9:0]    r_in_col;
    logic [8:0]    r_out_col;
    logic [8:0]    r_dcol;
    logic [9:0]    r_line_cnt;
    logic          r_toggle;
    logic          r_pass;
    logic [DW-1:0] r_rd;
    logic [DW-1:0] r_buf [0:DEPTH-1];

    logic          w_hedge;
    logic          w_fall;
    logic          w_wrap;
    logic          w_restart;
    logic          w_early;
    logic          w_vs_hit;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic          w_h_de;
    logic          w_v_de;
    logic          w_de;
    logic [DW-1:0] w_pix;
    logic [DW-1:0] w_vid;

    // A rising csync edge only marks a new line if the low pulse was too short for vsync.
    assign w_hedge   = i_csync_in & ~r_csd & (r_sync_len < VS_T);
    assign w_fall    = ~i_csync_in & r_csd;
    assign w_wrap    = (r_out_col == LAST_COL);
    assign w_restart = w_hedge | w_wrap;
    assign w_early   = w_hedge & ~w_wrap;
    assign w_vs_hit  = (r_sync_len == VS_T);

    assign w_wr_en   = ~i_reset & r_in_col[0] & ({1'b0, r_in_col[9:1]} < LEN_W);
    assign w_wr_addr = {r_toggle, r_in_col[9:1]};
    assign w_rd_addr = {~r_toggle, r_out_col};

    assign w_h_de = ({1'b0, r_dcol} >= HDE_S) & ({1'b0, r_dcol} < HDE_E);
    assign w_v_de = ({1'b0, r_line_cnt} >= VDE_S) & ({1'b0, r_line_cnt} < VDE_E);
    assign w_de   = w_h_de & w_v_de;
    assign w_pix  = r_rd ^ {DW{i_invert}};
    assign w_vid  = (i_scanlines & r_pass) ? (w_pix >> 1) : w_pix;

    // Sync separation: pulse length, vsync flag and source line counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_csd      <= 1'b0;
            r_sync_len <= 8'd0;
            r_line_cnt <= 10'd0;
            r_toggle   <= 1'b0;
            o_vs_out   <= 1'b0;
        end else begin
            r_csd <= i_csync_in;

            if (i_csync_in) begin
                r_sync_len <= 8'd0;
            end else if (r_sync_len != 8'hFF) begin
                r_sync_len <= r_sync_len + 8'd1;
            end

            if (i_csync_in) begin
                o_vs_out <= 1'b0;
            end else if (w_vs_hit) begin
                o_vs_out <= 1'b1;
            end

            if (w_vs_hit) begin
                r_line_cnt <= 10'd0;
            end else if (w_fall && (r_line_cnt != 10'h3FF)) begin
                r_line_cnt <= r_line_cnt + 10'd1;
            end

            if (w_fall) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

    // Input column runs at clk rate; pixels land on odd columns.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_in_col <= 10'd0;
        end else if (w_hedge) begin
            r_in_col <= 10'd0;
        end else if (r_in_col != 10'h3FF) begin
            r_in_col <= r_in_col + 10'd1;
        end
    end

    // Output column free-runs at LINE_LEN and is pulled back to 0 by every hedge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_col    <= 9'd0;
            r_dcol       <= 9'd0;
            r_pass       <= 1'b0;
            o_resync     <= 1'b0;
            o_resync_cnt <= 8'd0;
        end else begin
            r_out_col <= w_restart ? 9'd0 : r_out_col + 9'd1;
            r_dcol    <= r_out_col;
            if (w_restart) begin
                r_pass <= ~r_pass;
            end
            o_resync <= w_early;
            if (w_early && (o_resync_cnt != 8'hFF)) begin
                o_resync_cnt <= o_resync_cnt + 8'd1;
            end
        end
    end

    // Two-bank line store; the write and read banks always differ.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_addr] <= i_video_in;
        end
        r_rd <= r_buf[w_rd_addr];
    end

    // Output stage aligned with the 1-clk read latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_hs_out    <= 1'b0;
            o_de_out    <= 1'b0;
            o_video_out <= '0;
        end else begin
            o_hs_out    <= ({1'b0, r_dcol} >= HS_S);
            o_de_out    <= w_de;
            o_video_out <= w_de ? w_vid : '0;
        end
    end

endmodule

// File: tb/tb_zx_scandoubler.sv
// Randomized bench for zx_scandoubler: two instances (DW=4 and DW=1) share stimulus and are
// compared every clk against a cycle-level behavioural model, plus directed scenario checks.
module tb_zx_scandoubler;

    localparam int LL  = 414;
    localparam int VS  = 80;
    localparam int HDS = 64;
    localparam int HDE = 352;
    localparam int HS  = 384;
    localparam int VDS = 2;
    localparam int VDE = 40;

    logic       r_clk;
    logic       r_reset;
    logic       r_csync;
    logic [3:0] r_video;
    logic       r_invert;
    logic       r_scan;

    logic [3:0] w_vid4;
    logic       w_hs4, w_vs4, w_de4, w_rs4;
    logic [7:0] w_rc4;
    logic [0:0] w_vid1;
    logic       w_hs1, w_vs1, w_de1, w_rs1;
    logic [7:0] w_rc1;

    zx_scandoubler #(
        .DW(4), .LINE_LEN(LL), .VS_THRESH(VS), .H_DE_START(HDS), .H_DE_END(HDE),
        .HS_START(HS), .V_DE_START(VDS), .V_DE_END(VDE)
    ) u_dut4 (
        .i_clk(r_clk), .i_reset(r_reset), .i_csync_in(r_csync), .i_video_in(r_video),
        .i_invert(r_invert), .i_scanlines(r_scan), .o_video_out(w_vid4), .o_hs_out(w_hs4),
        .o_vs_out(w_vs4), .o_de_out(w_de4), .o_resync(w_rs4), .o_resync_cnt(w_rc4)
    );

    zx_scandoubler #(
        .DW(1), .LINE_LEN(LL), .VS_THRESH(VS), .H_DE_START(HDS), .H_DE_END(HDE),
        .HS_START(HS), .V_DE_START(VDS), .V_DE_END(VDE)
    ) u_dut1 (
        .i_clk(r_clk), .i_reset(r_reset), .i_csync_in(r_csync), .i_video_in(r_video[0:0]),
        .i_invert(r_invert), .i_scanlines(r_scan), .o_video_out(w_vid1), .o_hs_out(w_hs1),
        .o_vs_out(w_vs1), .o_de_out(w_de1), .o_resync(w_rs1), .o_resync_cnt(w_rc1)
    );

    always #5 r_clk = ~r_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    int m_csd, m_slen, m_incol, m_outcol, m_line, m_tog, m_pass;
    int m_rd, m_rdv, m_dcol;
    int m_hs, m_vs, m_de, m_vid4, m_vid1, m_vidv, m_rs, m_rsc;
    int m_mem  [1024];
    bit m_memv [1024];

    // Scenario counters stepped by every tick.
    int g_rs, g_hs, g_de, g_f, g_7, g_nz;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit rst, input bit cs, input int vin, input bit inv, input bit scan);
        bit hedge, fall, wrap, de;
        int p4, p1, rbank, wbank;
        if (rst) begin
            m_csd = 0; m_slen = 0; m_incol = 0; m_outcol = 0; m_line = 0; m_tog = 0; m_pass = 0;
            m_dcol = 0; m_hs = 0; m_vs = 0; m_de = 0; m_vid4 = 0; m_vid1 = 0; m_vidv = 1;
            m_rs = 0; m_rsc = 0; m_rdv = 0;
            return;
        end
        hedge = cs && (m_csd == 0) && (m_slen < VS);
        fall  = !cs && (m_csd != 0);
        wrap  = (m_outcol == LL - 1);
        // Output pixels come from the previous clk's read, at column m_dcol.
        de   = (m_dcol >= HDS) && (m_dcol < HDE) && (m_line >= VDS) && (m_line < VDE);
        p4   = (m_rd ^ (inv ? 15 : 0)) & 15;
        p1   = (m_rd ^ (inv ? 1 : 0)) & 1;
        m_hs = (m_dcol >= HS) ? 1 : 0;
        m_de = de ? 1 : 0;
        m_vidv = (!de || m_rdv != 0) ? 1 : 0;
        m_vid4 = !de ? 0 : ((scan && m_pass != 0) ? (p4 >> 1) : p4);
        m_vid1 = !de ? 0 : ((scan && m_pass != 0) ? 0 : p1);
        rbank = (m_tog != 0) ? 0 : 512;
        wbank = (m_tog != 0) ? 512 : 0;
        m_rd  = m_mem[rbank + m_outcol];
        m_rdv = m_memv[rbank + m_outcol] ? 1 : 0;
        if ((m_incol % 2 == 1) && (m_incol / 2 < LL)) begin
            m_mem[wbank + m_incol / 2]  = vin & 15;
            m_memv[wbank + m_incol / 2] = 1'b1;
        end
        m_dcol = m_outcol;
        m_rs   = (hedge && !wrap) ? 1 : 0;
        if (m_rs != 0 && m_rsc < 255) m_rsc++;
        m_outcol = (hedge || wrap) ? 0 : m_outcol + 1;
        if (hedge || wrap) m_pass = 1 - m_pass;
        m_incol = hedge ? 0 : imin(m_incol + 1, 1023);
        if (fall) begin
            m_tog  = 1 - m_tog;
            m_line = imin(m_line + 1, 1023);
        end
        if (m_slen == VS) m_line = 0;
        if (cs) m_vs = 0;
        else if (m_slen == VS) m_vs = 1;
        m_slen = cs ? 0 : imin(m_slen + 1, 255);
        m_csd  = cs ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("hs4", int'(w_hs4), m_hs);
        chk("vs4", int'(w_vs4), m_vs);
        chk("de4", int'(w_de4), m_de);
        chk("resync4", int'(w_rs4), m_rs);
        chk("resync_cnt4", int'(w_rc4), m_rsc);
        chk("hs1", int'(w_hs1), m_hs);
        chk("vs1", int'(w_vs1), m_vs);
        chk("de1", int'(w_de1), m_de);
        chk("resync1", int'(w_rs1), m_rs);
        chk("resync_cnt1", int'(w_rc1), m_rsc);
        if (m_vidv != 0) begin
            chk("video4", int'(w_vid4), m_vid4);
            chk("video1", int'(w_vid1), m_vid1);
        end
    endtask

    task automatic tick(input bit rst, input bit cs, input int vin, input bit inv, input bit scan);
        r_reset  = rst;
        r_csync  = cs;
        r_video  = 4'(vin);
        r_invert = inv;
        r_scan   = scan;
        @(posedge r_clk);
        model_step(rst, cs, vin, inv, scan);
        #1;
        compare_all();
        if (w_rs4) g_rs++;
        if (w_hs4) g_hs++;
        if (w_de4) g_de++;
        if (w_de4 && w_vid4 == 4'hF) g_f++;
        if (w_de4 && w_vid4 == 4'h7) g_7++;
        if (w_de4 && w_vid4 != 4'h0) g_nz++;
    endtask

    task automatic clr_counts();
        g_rs = 0; g_hs = 0; g_de = 0; g_f = 0; g_7 = 0; g_nz = 0;
    endtask

    // mode 0: random pixels, 1: pixel k = k mod 16, 2: constant 4'hF
    task automatic src_line(input int period, input int low, input int mode, input bit inv, input bit scan);
        for (int t = 0; t < period; t++) begin
            int v;
            case (mode)
                0:       v = int'($urandom_range(0, 15));
                1:       v = (m_incol / 2) % 16;
                default: v = 15;
            endcase
            tick(1'b0, (t >= low), v, inv, scan);
        end
    endtask

    initial begin
        int rc_before, rise_at, vs199, vs200, found;
        r_clk = 1'b0;
        r_reset = 1'b1; r_csync = 1'b1; r_video = 4'd0; r_invert = 1'b0; r_scan = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            m_mem[i] = 0;
            m_memv[i] = 1'b0;
        end
        clr_counts();
        tick(1'b1, 1'b1, 0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 0, 1'b0, 1'b0);

        // Reset held 4 clk in the middle of a line.
        src_line(300, 60, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, int'($urandom_range(0, 15)), 1'b1, 1'b1);
            chk("rst_video", int'(w_vid4), 0);
            chk("rst_hs", int'(w_hs4), 0);
            chk("rst_vs", int'(w_vs4), 0);
            chk("rst_de", int'(w_de4), 0);
            chk("rst_resync", int'(w_rs4), 0);
            chk("rst_resync_cnt", int'(w_rc4), 0);
        end

        // Regular 828-clk lines with 60-clk sync: a single resync, then locked.
        clr_counts();
        for (int l = 0; l < 6; l++) begin
            if (l == 5) g_hs = 0;
            src_line(828, 60, 0, 1'b0, 1'b0);
        end
        chk("t2_resync_pulses", g_rs, 1);
        chk("t2_resync_cnt", int'(w_rc4), 1);
        chk("t2_hs_per_2_lines", g_hs, 2 * (LL - HS));

        // Long sync pulse: vsync, and no resync at its rising edge.
        rc_before = int'(w_rc4);
        rise_at = -1; vs199 = -1; vs200 = -1;
        for (int t = 0; t < 828; t++) begin
            tick(1'b0, (t >= 200), int'($urandom_range(0, 15)), 1'b0, 1'b0);
            if (rise_at < 0 && w_vs4) rise_at = t + 1;
            if (t == 199) vs199 = int'(w_vs4);
            if (t == 200) vs200 = int'(w_vs4);
        end
        chk("t3_vs_rise_delay", rise_at, VS + 1);
        chk("t3_vs_high_before_rise", vs199, 1);
        chk("t3_vs_fall", vs200, 0);
        chk("t3_no_resync", int'(w_rc4), rc_before);

        // Ramp pixels; de window size per source line.
        for (int l = 0; l < 5; l++) begin
            clr_counts();
            src_line(828, 60, 1, 1'b0, 1'b0);
        end
        chk("t4_de_per_line", g_de, 2 * (HDE - HDS));
        chk("t4_rampnz_seen", (g_nz > 0) ? 1 : 0, 1);

        // Constant white with scanlines, then inverted.
        for (int l = 0; l < 3; l++) begin
            clr_counts();
            src_line(828, 60, 2, 1'b0, 1'b1);
        end
        chk("t5_full_count", g_f, HDE - HDS);
        chk("t5_dim_count", g_7, HDE - HDS);
        for (int l = 0; l < 2; l++) begin
            clr_counts();
            src_line(828, 60, 2, 1'b1, 1'b1);
        end
        chk("t5_inv_nonzero", g_nz, 0);
        chk("t5_inv_de", g_de, 2 * (HDE - HDS));

        // Random line lengths, sync widths, pixels and modes.
        for (int l = 0; l < 12; l++) begin
            src_line(int'($urandom_range(700, 900)), int'($urandom_range(20, 70)), 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Hedge forced at out_col 200.
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            tick(1'b0, 1'b1, 0, 1'b0, 1'b0);
            if (m_outcol == 196) found = 1;
        end
        chk("t6_reach_col", found, 1);
        rc_before = int'(w_rc1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("t6_resync_pulse", int'(w_rs1), 1);
        chk("t6_resync_inc", int'(w_rc1), imin(rc_before + 1, 255));
        tick(1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("t6_resync_one_clk", int'(w_rs1), 0);

        // Short lines resync every time; the counter must stop at 255.
        for (int l = 0; l < 260; l++) src_line(40, 4, 0, 1'b0, 1'b0);
        chk("t6_saturate1", int'(w_rc1), 255);
        chk("t6_saturate4", int'(w_rc4), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
